// File: rtl/jio_ctrl_pkg.sv
// Shared definitions for the jio_ctrl IO controller: status bit layout,
// CPU strobe opcodes and a constant-evaluable log2 helper.
package jio_ctrl_pkg;

    localparam int ST_OVF   = 7;
    localparam int ST_FULL  = 6;
    localparam int ST_EMPTY = 5;
    localparam int ST_INAV  = 4;

    // Opcode is {io_da, io_io}
    typedef enum logic [1:0] {
        OP_DATA_IN  = 2'b00,
        OP_DATA_OUT = 2'b01,
        OP_STAT_IN  = 2'b10,
        OP_ADDR_OUT = 2'b11
    } io_op_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/jio_fifo.sv
// Per-channel output FIFO; a push is accepted when not full or when the
// head is popping in the same cycle. The head reads as zero while empty.
module jio_fifo
    import jio_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);
    assign dout      = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are never observed while empty, so no reset
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/jio_ctrl.sv
// CPU IO strobe controller: addressed per-device output FIFOs, input holding
// registers and a readable status byte per channel.
module jio_ctrl
    import jio_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NDEV  = 4,
    parameter int DEPTH = 8
) (
    input  logic                  CLK,
    input  logic                  reset_n,
    input  logic                  io_s,
    input  logic                  io_e,
    input  logic                  io_da,
    input  logic                  io_io,
    input  logic [WIDTH-1:0]      bus_in,
    output logic [WIDTH-1:0]      bus_out,
    output logic [NDEV*WIDTH-1:0] out_data,
    output logic [NDEV-1:0]       out_valid,
    input  logic [NDEV-1:0]       out_ready,
    input  logic [NDEV*WIDTH-1:0] in_data,
    input  logic [NDEV-1:0]       in_valid,
    output logic [NDEV-1:0]       in_ready,
    output logic [WIDTH-1:0]      dev_sel
);

    logic                  io_s_q_r;
    logic                  io_e_q_r;
    logic [WIDTH-1:0]      dev_sel_r;
    logic                  rd_da_r;
    logic                  rd_io_r;
    logic [WIDTH-1:0]      rd_sel_r;
    logic [NDEV-1:0]       ovf_r;
    logic [NDEV-1:0]       full_h_r;
    logic [NDEV*WIDTH-1:0] hold_r;

    logic                  set_evt_s;
    logic                  rd_end_s;
    logic                  sel_ok_s;
    io_op_e                op_s;
    logic [NDEV-1:0]       push_s;
    logic [NDEV-1:0]       pop_s;
    logic [NDEV-1:0]       fifo_full_s;
    logic [NDEV-1:0]       fifo_empty_s;
    logic [NDEV-1:0]       ovf_set_s;
    logic [NDEV-1:0]       clr_h_s;
    logic [NDEV-1:0]       clr_ovf_s;

    assign set_evt_s = io_s & ~io_s_q_r;
    assign rd_end_s  = ~io_e & io_e_q_r;
    assign op_s      = io_op_e'({io_da, io_io});
    assign sel_ok_s  = (dev_sel_r < WIDTH'(NDEV));
    assign dev_sel   = dev_sel_r;
    assign out_valid = ~fifo_empty_s;
    assign in_ready  = ~full_h_r;

    for (genvar k = 0; k < NDEV; k++) begin : g_chan
        assign push_s[k]    = set_evt_s & (op_s == OP_DATA_OUT) & (dev_sel_r == WIDTH'(k));
        assign pop_s[k]     = ~fifo_empty_s[k] & out_ready[k];
        assign ovf_set_s[k] = push_s[k] & fifo_full_s[k] & ~pop_s[k];
        // Side effects use the selection latched during the read, not the live one
        assign clr_h_s[k]   = rd_end_s & ~rd_io_r & ~rd_da_r & (rd_sel_r == WIDTH'(k));
        assign clr_ovf_s[k] = rd_end_s & ~rd_io_r &  rd_da_r & (rd_sel_r == WIDTH'(k));

        jio_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
            .clk   (CLK),
            .rst_n (reset_n),
            .push  (push_s[k]),
            .din   (bus_in),
            .full  (fifo_full_s[k]),
            .pop   (pop_s[k]),
            .dout  (out_data[k*WIDTH +: WIDTH]),
            .empty (fifo_empty_s[k])
        );
    end

    // Strobe edge detection, address register and read-cycle latch
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            io_s_q_r  <= 1'b0;
            io_e_q_r  <= 1'b0;
            dev_sel_r <= {WIDTH{1'b0}};
            rd_da_r   <= 1'b0;
            rd_io_r   <= 1'b0;
            rd_sel_r  <= {WIDTH{1'b0}};
        end else begin
            io_s_q_r <= io_s;
            io_e_q_r <= io_e;
            if (set_evt_s && (op_s == OP_ADDR_OUT)) begin
                dev_sel_r <= bus_in;
            end
            if (io_e) begin
                rd_da_r  <= io_da;
                rd_io_r  <= io_io;
                rd_sel_r <= dev_sel_r;
            end
        end
    end

    // Overflow flags and input holding registers; a read clear beats a capture
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            ovf_r    <= {NDEV{1'b0}};
            full_h_r <= {NDEV{1'b0}};
            hold_r   <= {(NDEV*WIDTH){1'b0}};
        end else begin
            for (int k = 0; k < NDEV; k++) begin
                if (ovf_set_s[k]) begin
                    ovf_r[k] <= 1'b1;
                end else if (clr_ovf_s[k]) begin
                    ovf_r[k] <= 1'b0;
                end
                if (clr_h_s[k]) begin
                    full_h_r[k] <= 1'b0;
                end else if (in_valid[k] && !full_h_r[k]) begin
                    full_h_r[k]              <= 1'b1;
                    hold_r[k*WIDTH +: WIDTH] <= in_data[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Combinational read mux onto the wired-OR bus
    always_comb begin
        logic [WIDTH-1:0] sel_hold_s;
        logic [WIDTH-1:0] sel_stat_s;
        logic             sel_full_s;
        sel_hold_s = {WIDTH{1'b0}};
        sel_stat_s = {WIDTH{1'b0}};
        sel_full_s = 1'b0;
        bus_out    = {WIDTH{1'b0}};
        for (int k = 0; k < NDEV; k++) begin
            if (dev_sel_r == WIDTH'(k)) begin
                sel_hold_s           = hold_r[k*WIDTH +: WIDTH];
                sel_full_s           = full_h_r[k];
                sel_stat_s[ST_OVF]   = ovf_r[k];
                sel_stat_s[ST_FULL]  = fifo_full_s[k];
                sel_stat_s[ST_EMPTY] = fifo_empty_s[k];
                sel_stat_s[ST_INAV]  = full_h_r[k];
            end else begin
                sel_hold_s = sel_hold_s;
            end
        end
        if (io_e && !io_io && sel_ok_s) begin
            if (io_da) begin
                bus_out = sel_stat_s;
            end else if (sel_full_s) begin
                bus_out = sel_hold_s;
            end else begin
                bus_out = {WIDTH{1'b0}};
            end
        end else begin
            bus_out = {WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_jio_ctrl.sv
// Directed plus randomized bench for jio_ctrl against a queue-based reference
// model of the channel FIFOs, holding registers and flags.
module tb_jio_ctrl;

    localparam int W = 8;
    localparam int N = 4;
    localparam int D = 8;

    logic           CLK = 1'b0;
    logic           reset_n;
    logic           io_s, io_e, io_da, io_io;
    logic [W-1:0]   bus_in;
    logic [W-1:0]   bus_out;
    logic [N*W-1:0] out_data;
    logic [N-1:0]   out_valid;
    logic [N-1:0]   out_ready;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   dev_sel;

    int passes = 0;
    int total  = 0;

    // Reference model state
    logic [W-1:0] mq [N][$];
    logic         m_ovf [N];
    logic         m_hv  [N];
    logic [W-1:0] m_hold [N];
    logic [W-1:0] m_sel, m_rsel;
    logic         m_sq, m_eq, m_rda, m_rio;

    jio_ctrl #(.WIDTH(W), .NDEV(N), .DEPTH(D)) dut (
        .CLK(CLK), .reset_n(reset_n), .io_s(io_s), .io_e(io_e), .io_da(io_da),
        .io_io(io_io), .bus_in(bus_in), .bus_out(bus_out), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .dev_sel(dev_sel)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mq[k].delete();
            m_ovf[k] = 1'b0; m_hv[k] = 1'b0; m_hold[k] = '0;
        end
        m_sel = '0; m_rsel = '0; m_sq = 1'b0; m_eq = 1'b0; m_rda = 1'b0; m_rio = 1'b0;
    endtask

    function automatic logic [W-1:0] exp_bus();
        logic [W-1:0] r;
        r = '0;
        if (io_e && !io_io && m_sel < N) begin
            if (io_da)
                r = {m_ovf[m_sel], mq[m_sel].size() == D, mq[m_sel].size() == 0, m_hv[m_sel], 4'b0000};
            else if (m_hv[m_sel])
                r = m_hold[m_sel];
        end
        return r;
    endfunction

    // Apply one clock edge's worth of behaviour to the model from current inputs
    task automatic model_edge();
        logic set, rde;
        logic [N-1:0] clr_h;
        set = io_s && !m_sq;
        rde = !io_e && m_eq;
        clr_h = '0;
        for (int k = 0; k < N; k++)
            if (mq[k].size() > 0 && out_ready[k]) void'(mq[k].pop_front());
        if (rde && !m_rio && m_rsel < N) begin
            if (m_rda) m_ovf[m_rsel] = 1'b0;
            else clr_h[m_rsel[1:0]] = 1'b1;
        end
        if (set && !io_da && io_io && m_sel < N) begin
            if (mq[m_sel].size() < D) mq[m_sel].push_back(bus_in);
            else m_ovf[m_sel] = 1'b1;
        end
        for (int k = 0; k < N; k++) begin
            if (clr_h[k]) m_hv[k] = 1'b0;
            else if (in_valid[k] && !m_hv[k]) begin
                m_hv[k] = 1'b1;
                m_hold[k] = in_data[k*W +: W];
            end
        end
        if (io_e) begin m_rda = io_da; m_rio = io_io; m_rsel = m_sel; end
        if (set && io_da && io_io) m_sel = bus_in;
        m_sq = io_s;
        m_eq = io_e;
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, ":dev_sel"}, 32'(dev_sel), 32'(m_sel));
        chk({tag, ":bus_out"}, 32'(bus_out), 32'(exp_bus()));
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s:out_valid%0d", tag, k), 32'(out_valid[k]), 32'(mq[k].size() > 0));
            chk($sformatf("%s:out_data%0d", tag, k), 32'(out_data[k*W +: W]),
                32'(mq[k].size() > 0 ? mq[k][0] : 8'h00));
            chk($sformatf("%s:in_ready%0d", tag, k), 32'(in_ready[k]), 32'(!m_hv[k]));
        end
    endtask

    task automatic tick(input string tag);
        check_all(tag);
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic strobe(input string tag, input logic da, input logic [W-1:0] v);
        io_da = da; io_io = 1'b1; bus_in = v; io_s = 1'b1;
        tick(tag);
        io_s = 1'b0;
        tick(tag);
    endtask

    task automatic cpu_read(input string tag, input logic da, input logic [W-1:0] exp);
        io_da = da; io_io = 1'b0; io_e = 1'b1;
        #1;
        chk({tag, ":read"}, 32'(bus_out), 32'(exp));
        tick(tag);
        io_e = 1'b0;
        tick(tag);
    endtask

    initial begin
        reset_n = 1'b0; io_s = 0; io_e = 0; io_da = 0; io_io = 0; bus_in = '0;
        out_ready = '0; in_data = '0; in_valid = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_all("reset");
        reset_n = 1'b1;

        // Two bytes drained by a ready device on channel 0
        strobe("t1_addr", 1'b1, 8'h00);
        out_ready = 4'b0001;
        strobe("t1_w41", 1'b0, 8'h41);
        strobe("t1_w42", 1'b0, 8'h42);
        repeat (2) tick("t1_drain");
        chk("t1_empty", 32'(out_valid[0]), 32'd0);
        out_ready = '0;

        // Long strobe queues exactly one byte
        strobe("t2_addr", 1'b1, 8'h01);
        io_da = 1'b0; io_io = 1'b1; bus_in = 8'h77; io_s = 1'b1;
        repeat (10) tick("t2_hold");
        io_s = 1'b0;
        tick("t2_rel");
        out_ready = 4'b0010;
        tick("t2_pop");
        tick("t2_after");
        chk("t2_one_entry", 32'(out_valid[1]), 32'd0);
        out_ready = '0;

        // Overflow on channel 2
        strobe("t3_addr", 1'b1, 8'h02);
        for (int i = 0; i < 9; i++) strobe("t3_fill", 1'b0, 8'(8'h10 + i));
        cpu_read("t3_stat1", 1'b1, 8'hC0);
        out_ready = 4'b0100;
        for (int i = 0; i < 9; i++) tick("t3_drain");
        out_ready = '0;
        cpu_read("t3_stat2", 1'b1, 8'h20);

        // Input capture and data read on channel 3
        in_valid = 4'b1000; in_data = {8'h5A, 24'h0};
        tick("t4_cap");
        in_valid = '0;
        strobe("t4_addr", 1'b1, 8'h03);
        cpu_read("t4_read", 1'b0, 8'h5A);
        chk("t4_in_ready", 32'(in_ready[3]), 32'd1);

        // Out-of-range selection
        strobe("t5_addr", 1'b1, 8'h07);
        strobe("t5_w33", 1'b0, 8'h33);
        cpu_read("t5_data", 1'b0, 8'h00);
        cpu_read("t5_stat", 1'b1, 8'h00);

        // Reset mid-stream
        strobe("t6_addr", 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) strobe("t6_fill", 1'b0, 8'(8'hA0 + i));
        in_valid = 4'b0010; in_data = {16'h0, 8'hEE, 8'h0};
        tick("t6_cap");
        in_valid = '0;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'hF);
        chk("t6_dev_sel", 32'(dev_sel), 32'd0);
        chk("t6_bus_out", 32'(bus_out), 32'd0);
        @(posedge CLK);
        #1;
        reset_n = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            io_s      = 1'($urandom_range(0, 1));
            io_e      = ($urandom_range(0, 3) == 0);
            io_da     = 1'($urandom_range(0, 1));
            io_io     = 1'($urandom_range(0, 1));
            bus_in    = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 5)) : 8'($urandom);
            out_ready = 4'($urandom);
            in_valid  = 4'($urandom);
            in_data   = 32'($urandom);
            tick("rand");
        end
        io_s = 0; io_e = 0; in_valid = '0;
        tick("rand_end");
        check_all("final");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
